// File: rtl/traffic_conflict_monitor.sv
// Safety monitor on the controller's r/g lamp bus: checks one-green, r==~g, round-robin order and
// green dwell window; latches a sticky fault with the first cause. Latency 2 edges; no backpressure.
module traffic_conflict_monitor #(
    parameter int N_LANES    = 4,
    parameter int FIRST_LANE = 0,
    parameter int MIN_GREEN  = 11,
    parameter int MAX_GREEN  = 11,
    parameter int CNT_W      = 5,
    localparam int LW        = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_LANES-1:0] r_in,
    input  logic [N_LANES-1:0] g_in,
    input  logic               clr_fault,
    output logic               fault,
    output logic [2:0]         fault_code,
    output logic [LW-1:0]      active_lane,
    output logic               lane_valid,
    output logic [CNT_W-1:0]   dwell_cnt,
    output logic [7:0]         rotations
);

    typedef enum logic [1:0] {
        S_DARK  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    localparam logic [2:0] C_NONE     = 3'd0;
    localparam logic [2:0] C_CONFLICT = 3'd1;
    localparam logic [2:0] C_MISMATCH = 3'd2;
    localparam logic [2:0] C_SEQUENCE = 3'd3;
    localparam logic [2:0] C_SHORT    = 3'd4;
    localparam logic [2:0] C_LONG     = 3'd5;
    localparam logic [2:0] C_NOGREEN  = 3'd6;

    logic [N_LANES-1:0] r_q, g_q;
    state_t             state_q, state_d;
    logic [2:0]         code_q, code_d;
    logic [LW-1:0]      active_q, active_d;
    logic [CNT_W-1:0]   dwell_q, dwell_d;
    logic [7:0]         rot_q, rot_d;

    logic [LW:0]        g_cnt;
    logic [LW-1:0]      g_idx;
    logic               conflict, mismatch, no_green_dark;
    logic [LW-1:0]      nxt_lane;
    logic [2:0]         viol;

    always_comb begin
        g_cnt = '0;
        g_idx = '0;
        for (int i = 0; i < N_LANES; i++) begin
            if (g_q[i]) begin
                g_cnt = g_cnt + 1'b1;
                g_idx = LW'(i);
            end
        end
    end

    assign conflict      = (g_cnt > 1);
    assign mismatch      = (g_cnt == 1) && (r_q != ~g_q);
    assign no_green_dark = (g_q == '0) && (r_q != '0);
    assign nxt_lane      = (active_q == LW'(N_LANES - 1)) ? '0 : active_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        active_d = active_q;
        dwell_d  = dwell_q;
        rot_d    = rot_q;
        viol     = C_NONE;

        // Branch order below encodes the cause priority 1 > 2 > 6 > 3 > 4 > 5.
        case (state_q)
            S_DARK: begin
                if (conflict)                      viol = C_CONFLICT;
                else if (mismatch)                 viol = C_MISMATCH;
                else if (no_green_dark)            viol = C_NOGREEN;
                else if (g_q != '0) begin
                    if (g_idx != LW'(FIRST_LANE))  viol = C_SEQUENCE;
                    else begin
                        state_d  = S_RUN;
                        active_d = g_idx;
                        dwell_d  = CNT_W'(1);
                    end
                end
            end
            S_RUN: begin
                if (conflict)                      viol = C_CONFLICT;
                else if (mismatch)                 viol = C_MISMATCH;
                else if (g_q == '0)                viol = C_NOGREEN;
                else if (g_idx == active_q) begin
                    if (dwell_q == CNT_W'(MAX_GREEN)) viol = C_LONG;
                    else                           dwell_d = dwell_q + 1'b1;
                end
                else if (g_idx != nxt_lane)        viol = C_SEQUENCE;
                else if (dwell_q < CNT_W'(MIN_GREEN)) viol = C_SHORT;
                else begin
                    active_d = g_idx;
                    dwell_d  = CNT_W'(1);
                    if (g_idx == '0 && active_q == LW'(N_LANES - 1))
                        rot_d = rot_q + 1'b1;
                end
            end
            default: ;
        endcase

        if (viol != C_NONE) begin
            state_d = S_FAULT;
            code_d  = viol;
        end

        if (clr_fault) begin
            state_d  = S_DARK;
            code_d   = C_NONE;
            active_d = '0;
            dwell_d  = '0;
            rot_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q      <= '0;
            g_q      <= '0;
            state_q  <= S_DARK;
            code_q   <= C_NONE;
            active_q <= '0;
            dwell_q  <= '0;
            rot_q    <= '0;
        end else begin
            r_q      <= r_in;
            g_q      <= g_in;
            state_q  <= state_d;
            code_q   <= code_d;
            active_q <= active_d;
            dwell_q  <= dwell_d;
            rot_q    <= rot_d;
        end
    end

    assign fault       = (state_q == S_FAULT);
    assign lane_valid  = (state_q == S_RUN);
    assign fault_code  = code_q;
    assign active_lane = active_q;
    assign dwell_cnt   = dwell_q;
    assign rotations   = rot_q;

endmodule
